dclcg_combiner: RTL and testbench
=================================

Name: dclcg_combiner

Overview:
- Downstream consumer of the four LCG stages in the modified dual-CLCG generator.
- Each accepted sample is four LCG states (x1, x2, y1, y2). The block forms two comparison bits, B = (x1 > x2) and C = (y1 > y2), and emits one random bit Z = B xor C per sample.
- Packs Z bits into words and presents them on a valid/ready output.
- Discards a configurable warm-up run after start, and back-pressures the LCGs when the output word is not taken.

Parameters:
- DATA_W, 4: width of each LCG state input.
- WORD_W, 8: random bits per output word (>= 2).
- WARMUP, 4: accepted samples discarded after start (0 allowed).
- CNT_W, 16: width of the generated-word counter.

Ports:
- clk1, input, 1: single system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: level; high = generate, low = stop and return to IDLE.
- sample_valid, input, 1: x1/x2/y1/y2 hold a fresh LCG sample.
- x1, input, DATA_W: state of CLCG-1 LCG A.
- x2, input, DATA_W: state of CLCG-1 LCG B.
- y1, input, DATA_W: state of CLCG-2 LCG A.
- y2, input, DATA_W: state of CLCG-2 LCG B.
- sample_ready, output, 1: sample accepted this cycle if sample_valid is also high; upstream LCGs must hold state while low.
- rnd_word, output, WORD_W: completed random word.
- rnd_valid, output, 1: rnd_word is valid.
- rnd_ready, input, 1: consumer takes rnd_word.
- bit_out, output, 1: last Z bit produced.
- bit_strobe, output, 1: one-cycle pulse when bit_out is updated.
- word_cnt, output, CNT_W: count of words loaded into rnd_word since reset.
- busy, output, 1: state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all counters 0, shift register 0.
  - rnd_word=0, rnd_valid=0, bit_out=0, bit_strobe=0, word_cnt=0, sample_ready=0.
- Accept = sample_valid & sample_ready, evaluated at the rising edge of clk1.
- Comparisons are unsigned and strict: equal values give 0.
- States:
  - IDLE: sample_ready=0.
    - start=1 -> WARMUP if WARMUP>0, else RUN. Warm-up and bit counters cleared.
  - WARMUP: sample_ready=1. Each accept increments warm_cnt; no bits are produced.
    - Accept with warm_cnt==WARMUP-1 -> RUN.
  - RUN: each accept shifts Z in LSB-side: sh = {sh[WORD_W-2:0], Z}, bit_cnt++.
    - bit_out<=Z and bit_strobe=1 on the next cycle.
    - Accept with bit_cnt==WORD_W-1 loads rnd_word<={sh[WORD_W-2:0], Z}, sets rnd_valid, increments word_cnt (wraps modulo 2^CNT_W) and clears bit_cnt.
    - The first bit of a word ends up at the MSB.
- Any state, start=0 -> IDLE next cycle. The partial word and warm-up progress are discarded.
  - rnd_valid and rnd_word are retained until the word is handshaken.
  - start=0 takes priority over a same-cycle accept, so no bit is recorded.
- Output handshake:
  - rnd_valid & rnd_ready clears rnd_valid unless a new word loads the same cycle, in which case rnd_valid stays 1 with the new word.
  - rnd_word is stable while rnd_valid=1 and rnd_ready=0.
- Backpressure: in RUN, sample_ready = !(bit_cnt==WORD_W-1 & rnd_valid & !rnd_ready). The final bit of a word is stalled, never dropped.
- Latency: the last sample of a word is accepted at edge N; rnd_valid=1 after edge N (visible cycle N+1).
- rst mid-operation returns everything to the reset values immediately, independent of clk1.

Decomposition:
- Shared package dclcg_pkg holds:
  - the state enum (IDLE, WARMUP, RUN);
  - default DATA_W/WORD_W constants;
  - the Z function (compare and xor).
- One sub-module, dclcg_packer: the shift register, bit_cnt, output register and handshake. It takes z/z_valid/start and provides stall.
- The top-level holds the FSM, the warm-up counter and the compare logic.

Test Plan (DATA_W=4, WORD_W=8, WARMUP=2):
- Reset: rst=1 mid-run -> all outputs 0 immediately, state IDLE, busy=0.
- Warm-up: start=1, two samples accepted -> no bit_strobe; the third sample (x1=9, x2=3, y1=2, y2=7: B=1, C=0) -> bit_out=1, bit_strobe pulse.
- Word pack: 8 samples with Z pattern 1,0,1,1,0,0,1,0, rnd_ready=1 -> rnd_word=8'hB2, rnd_valid for 1 cycle, word_cnt=1.
- Equality: x1=x2=5, y1=4, y2=4 -> Z=0; x1=x2=5, y1=6, y2=4 -> Z=1.
- Backpressure: rnd_ready=0 after the first word and 7 more bits -> sample_ready=0 and rnd_word holds 8'hB2; raise rnd_ready -> the 8th bit is accepted that cycle and the second word loads with rnd_valid staying 1.
- Stop: start=0 after 3 bits of a word -> IDLE, sample_ready=0. Restart -> 2 warm-up samples again, then a fresh word starting at bit_cnt=0.

Source files
------------

// File: rtl/dclcg_pkg.sv
// -----------------------------------------------------------------------------
// dclcg_pkg
// Shared definitions for the dual-CLCG output combiner.
//   - state_e      : combiner FSM states (idle, warm-up discard, bit generation)
//   - DEF_DATA_W   : default width of each LCG state word
//   - DEF_WORD_W   : default number of random bits per output word
//   - Z_MAX_W      : widest LCG state accepted by calc_z (callers zero-extend)
//   - calc_z()     : Z = (x1 > x2) xor (y1 > y2), unsigned and strict
// -----------------------------------------------------------------------------
package dclcg_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_WORD_W = 8;
    localparam int Z_MAX_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

    // Operands arrive zero-extended to Z_MAX_W, so the magnitude compare is
    // unsigned for any DATA_W up to Z_MAX_W. Equal operands compare to 0.
    function automatic logic calc_z(
        input logic [Z_MAX_W-1:0] x1,
        input logic [Z_MAX_W-1:0] x2,
        input logic [Z_MAX_W-1:0] y1,
        input logic [Z_MAX_W-1:0] y2
    );
        logic b;
        logic c;
        b = (x1 > x2);
        c = (y1 > y2);
        return b ^ c;
    endfunction

endpackage

// File: rtl/dclcg_packer.sv
// -----------------------------------------------------------------------------
// dclcg_packer
// Packs Z bits into WORD_W-bit words and presents them on a valid/ready port.
// The first bit of a word ends up in the MSB.
//
// Ports:
//   clk1        in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   low discards the partial word (bit counter + shift reg)
//   z           in   Z bit of the accepted sample
//   z_valid     in   a RUN-state sample was accepted this cycle
//   rnd_ready   in   consumer takes rnd_word
//   stall       out  the final bit of a word cannot be stored yet
//   rnd_word    out  completed random word
//   rnd_valid   out  rnd_word is valid
//   bit_out     out  last Z bit produced
//   bit_strobe  out  one-cycle pulse when bit_out updates
//   word_cnt    out  words loaded into rnd_word since reset (wraps)
// -----------------------------------------------------------------------------
module dclcg_packer
    import dclcg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              z,
    input  logic              z_valid,
    input  logic              rnd_ready,
    output logic              stall,
    output logic [WORD_W-1:0] rnd_word,
    output logic              rnd_valid,
    output logic              bit_out,
    output logic              bit_strobe,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    // The shift register only holds the WORD_W-1 bits that precede the
    // final bit; the final bit goes straight into rnd_word with them.
    logic [WORD_W-2:0] sh_q,        sh_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [WORD_W-1:0] rnd_word_q,  rnd_word_d;
    logic              rnd_valid_q, rnd_valid_d;
    logic              bit_out_q,   bit_out_d;
    logic              bit_strobe_q, bit_strobe_d;
    logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;

    logic              last_bit;
    logic [WORD_W-1:0] full_word;

    assign last_bit  = (bit_cnt_q == BIT_LAST);
    assign full_word = {sh_q, z};

    // The last bit of a word must wait while the previous word is still
    // unread, so it is stalled upstream rather than dropped here.
    assign stall = last_bit & rnd_valid_q & ~rnd_ready;

    always_comb begin
        // NOTE: every variable gets its hold value first so that no path
        // through the branches below leaves it unassigned (no latch).
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        rnd_word_d   = rnd_word_q;
        rnd_valid_d  = rnd_valid_q;
        bit_out_d    = bit_out_q;
        bit_strobe_d = 1'b0;
        word_cnt_d   = word_cnt_q;

        if (rnd_valid_q && rnd_ready) begin
            rnd_valid_d = 1'b0;
        end

        if (!start) begin
            sh_d      = '0;
            bit_cnt_d = '0;
        end else if (z_valid) begin
            bit_out_d    = z;
            bit_strobe_d = 1'b1;
            sh_d         = full_word[WORD_W-2:0];
            if (last_bit) begin
                // A load in the same cycle as a handshake keeps rnd_valid high.
                rnd_word_d  = full_word;
                rnd_valid_d = 1'b1;
                word_cnt_d  = word_cnt_q + 1'b1;
                bit_cnt_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the data registers (shift register, rnd_word) are reset along
    // with the control state so every output is defined the moment rst rises.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            rnd_word_q   <= '0;
            rnd_valid_q  <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_strobe_q <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            rnd_word_q   <= rnd_word_d;
            rnd_valid_q  <= rnd_valid_d;
            bit_out_q    <= bit_out_d;
            bit_strobe_q <= bit_strobe_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign rnd_word   = rnd_word_q;
    assign rnd_valid  = rnd_valid_q;
    assign bit_out    = bit_out_q;
    assign bit_strobe = bit_strobe_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: rtl/dclcg_combiner.sv
// -----------------------------------------------------------------------------
// dclcg_combiner
// Output stage of the modified dual-CLCG generator. Each accepted sample of
// the four LCG states yields Z = (x1 > x2) xor (y1 > y2); after a warm-up run
// of WARMUP discarded samples, Z bits are packed into WORD_W-bit words.
//
// Ports:
//   clk1          in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   level: high = generate, low = return to IDLE
//   sample_valid  in   x1/x2/y1/y2 hold a fresh LCG sample
//   x1, x2        in   CLCG-1 LCG A / LCG B states
//   y1, y2        in   CLCG-2 LCG A / LCG B states
//   sample_ready  out  sample accepted when sample_valid is also high
//   rnd_word      out  completed random word
//   rnd_valid     out  rnd_word is valid
//   rnd_ready     in   consumer takes rnd_word
//   bit_out       out  last Z bit produced
//   bit_strobe    out  one-cycle pulse when bit_out updates
//   word_cnt      out  words loaded since reset
//   busy          out  FSM is not IDLE
// -----------------------------------------------------------------------------
module dclcg_combiner
    import dclcg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int WARMUP = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] y1,
    input  logic [DATA_W-1:0] y2,
    output logic              sample_ready,
    output logic [WORD_W-1:0] rnd_word,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              bit_out,
    output logic              bit_strobe,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    localparam int WARM_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int WARM_LAST = (WARMUP > 0) ? (WARMUP - 1) : 0;

    state_e            state_q, state_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;

    logic accept;
    logic z;
    logic z_valid;
    logic stall;

    assign accept = sample_valid & sample_ready;

    assign z = calc_z(Z_MAX_W'(x1), Z_MAX_W'(x2), Z_MAX_W'(y1), Z_MAX_W'(y2));

    // start=0 wins over a same-cycle accept: no bit is recorded.
    assign z_valid = accept & start & (state_q == ST_RUN);

    // State register
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // its pre-edge inputs; combinational processes use blocking assignments.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Next-state logic, including warm-up progress
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                warm_cnt_d = '0;
                if (start) begin
                    state_d = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
                end
            end

            ST_WARMUP: begin
                if (!start) begin
                    state_d    = ST_IDLE;
                    warm_cnt_d = '0;
                end else if (accept) begin
                    if (warm_cnt_q == WARM_W'(WARM_LAST)) begin
                        state_d    = ST_RUN;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                warm_cnt_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        sample_ready = 1'b0;
        busy         = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE:   sample_ready = 1'b0;
            ST_WARMUP: sample_ready = 1'b1;
            ST_RUN:    sample_ready = ~stall;
            default:   sample_ready = 1'b0;
        endcase
    end

    dclcg_packer #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .z          (z),
        .z_valid    (z_valid),
        .rnd_ready  (rnd_ready),
        .stall      (stall),
        .rnd_word   (rnd_word),
        .rnd_valid  (rnd_valid),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .word_cnt   (word_cnt)
    );

endmodule

// File: tb/tb_dclcg_combiner.sv
// -----------------------------------------------------------------------------
// tb_dclcg_combiner
// Directed scoreboard bench for dclcg_combiner (DATA_W=4, WORD_W=8, WARMUP=2).
// Stimulus pushes hand-computed Z bits and words into queues; a monitor pops
// and compares whenever bit_strobe pulses or a word handshake happens.
// -----------------------------------------------------------------------------
module tb_dclcg_combiner;

    localparam int DATA_W = 4;
    localparam int WORD_W = 8;
    localparam int WARMUP = 2;
    localparam int CNT_W  = 16;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              start;
    logic              sample_valid;
    logic [DATA_W-1:0] x1, x2, y1, y2;
    logic              sample_ready;
    logic [WORD_W-1:0] rnd_word;
    logic              rnd_valid;
    logic              rnd_ready;
    logic              bit_out;
    logic              bit_strobe;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;

    always #5 clk1 = ~clk1;

    dclcg_combiner #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .WARMUP (WARMUP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .x1           (x1),
        .x2           (x2),
        .y1           (y1),
        .y2           (y2),
        .sample_ready (sample_ready),
        .rnd_word     (rnd_word),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .bit_out      (bit_out),
        .bit_strobe   (bit_strobe),
        .word_cnt     (word_cnt),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0] a, b, c, d;
        logic       z;
    } vec_t;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic [CNT_W-1:0]  cnt;
    } exp_word_t;

    logic      exp_bits[$];
    exp_word_t exp_words[$];
    int        checks = 0;
    int        errors = 0;

    // Hand-computed samples: z = (a > b) xor (c > d)
    vec_t v10, v00, v01, v11, veq0, veq1, vmax, vtop;
    vec_t tbl[4][8];

    function automatic vec_t mk(int a, int b, int c, int d, logic z);
        vec_t v;
        v.a = 4'(a); v.b = 4'(b); v.c = 4'(c); v.d = 4'(d); v.z = z;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) until the driven sample is accepted; returns at edge+1.
    task automatic wait_accept();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk1);
            if (sample_ready) done = 1'b1;
            @(posedge clk1);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: sample_ready stayed %0b, required 1", sample_ready);
        end
    endtask

    task automatic drive(vec_t v, bit record);
        x1 = v.a; x2 = v.b; y1 = v.c; y2 = v.d;
        sample_valid = 1'b1;
        if (record) exp_bits.push_back(v.z);
    endtask

    task automatic send(vec_t v, bit record);
        drive(v, record);
        wait_accept();
        sample_valid = 1'b0;
    endtask

    task automatic send_word(int idx, logic [WORD_W-1:0] w, logic [CNT_W-1:0] c);
        exp_word_t e;
        e.word = w;
        e.cnt  = c;
        exp_words.push_back(e);
        for (int i = 0; i < WORD_W; i++) send(tbl[idx][i], 1'b1);
    endtask

    // Monitor: compares DUT output events against the scoreboard queues.
    initial begin
        exp_word_t e;
        logic      eb;
        forever begin
            @(negedge clk1);
            if (rst !== 1'b1) begin
                if (bit_strobe) begin
                    if (exp_bits.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: bit_out=%0b, no bit expected", bit_out);
                    end else begin
                        eb = exp_bits.pop_front();
                        check("bit_out", 32'(bit_out), 32'(eb));
                    end
                end
                if (rnd_valid && rnd_ready) begin
                    if (exp_words.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: rnd_word=%0h, no word expected", rnd_word);
                    end else begin
                        e = exp_words.pop_front();
                        check("rnd_word", 32'(rnd_word), 32'(e.word));
                        check("word_cnt", 32'(word_cnt), 32'(e.cnt));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(string tag);
        check({tag, "_rnd_word"},     32'(rnd_word), 0);
        check({tag, "_rnd_valid"},    32'(rnd_valid), 0);
        check({tag, "_bit_out"},      32'(bit_out), 0);
        check({tag, "_bit_strobe"},   32'(bit_strobe), 0);
        check({tag, "_word_cnt"},     32'(word_cnt), 0);
        check({tag, "_sample_ready"}, 32'(sample_ready), 0);
        check({tag, "_busy"},         32'(busy), 0);
    endtask

    initial begin
        v10  = mk(9, 3, 2, 7, 1'b1);
        v00  = mk(3, 9, 2, 7, 1'b0);
        v01  = mk(3, 9, 7, 2, 1'b1);
        v11  = mk(9, 3, 7, 2, 1'b0);
        veq0 = mk(5, 5, 4, 4, 1'b0);
        veq1 = mk(5, 5, 6, 4, 1'b1);
        vmax = mk(15, 0, 0, 15, 1'b1);
        vtop = mk(0, 15, 15, 15, 1'b0);
        // 8'hB2 = 1011_0010
        tbl[0] = '{v10, v00, v01, v10, v00, v11, v01, v00};
        // 8'h6D = 0110_1101 (equality and extreme values)
        tbl[1] = '{veq0, veq1, vmax, vtop, v10, v01, v11, v10};
        // 8'hF0 = 1111_0000
        tbl[2] = '{v10, v01, veq1, vmax, v00, v11, veq0, vtop};
        tbl[3] = tbl[0];

        rst = 1'b1; start = 1'b0; sample_valid = 1'b0; rnd_ready = 1'b1;
        x1 = '0; x2 = '0; y1 = '0; y2 = '0;

        repeat (2) @(negedge clk1);
        check_all_zero("reset");
        @(posedge clk1); #1;
        rst = 1'b0;

        // Start: IDLE -> WARMUP
        @(posedge clk1); #1;
        start = 1'b1;
        @(posedge clk1); #1;
        check("start_busy", 32'(busy), 1);
        check("warmup_ready", 32'(sample_ready), 1);

        // Two discarded warm-up samples; a strobe here is flagged by the monitor
        send(v10, 1'b0);
        send(v10, 1'b0);

        // Word 1 consumed immediately, word 2 exercises equality
        send_word(0, 8'hB2, 16'd1);
        send_word(1, 8'h6D, 16'd2);
        @(negedge clk1);
        @(posedge clk1); #1;
        check("word2_taken", 32'(rnd_valid), 0);
        rnd_ready = 1'b0;

        // Word 3 loads and is held
        send_word(3, 8'hB2, 16'd3);
        @(negedge clk1);
        check("hold_valid", 32'(rnd_valid), 1);
        check("hold_word", 32'(rnd_word), 32'h0B2);
        @(posedge clk1); #1;

        // Word 4: 7 bits pass, the 8th stalls
        begin
            exp_word_t e;
            e.word = 8'hF0;
            e.cnt  = 16'd4;
            exp_words.push_back(e);
        end
        for (int i = 0; i < WORD_W - 1; i++) send(tbl[2][i], 1'b1);
        drive(tbl[2][WORD_W-1], 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk1);
            check("stall_ready", 32'(sample_ready), 0);
            check("stall_word", 32'(rnd_word), 32'h0B2);
            check("stall_valid", 32'(rnd_valid), 1);
            @(posedge clk1); #1;
        end
        rnd_ready = 1'b1;
        wait_accept();
        sample_valid = 1'b0;
        check("reload_valid", 32'(rnd_valid), 1);
        check("reload_word", 32'(rnd_word), 32'h0F0);

        // Stop after 3 bits of a word, then restart with a fresh warm-up
        send(v10, 1'b1);
        send(v10, 1'b1);
        send(v10, 1'b1);
        start = 1'b0;
        @(posedge clk1); #1;
        check("stop_ready", 32'(sample_ready), 0);
        check("stop_busy", 32'(busy), 0);
        start = 1'b1;
        @(posedge clk1); #1;
        check("restart_busy", 32'(busy), 1);
        send(v00, 1'b0);
        send(v01, 1'b0);
        send_word(0, 8'hB2, 16'd5);
        repeat (2) @(negedge clk1);
        check("final_cnt", 32'(word_cnt), 5);
        check("final_word_retained", 32'(rnd_word), 32'h0B2);
        check("final_valid", 32'(rnd_valid), 0);

        // Asynchronous reset mid-run, checked before any further clock edge
        @(posedge clk1); #1;
        send(v10, 1'b0);
        rst = 1'b1;
        #2;
        check_all_zero("midrst");
        sample_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk1);

        check("bits_left", 32'(exp_bits.size()), 0);
        check("words_left", 32'(exp_words.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
